// File: rtl/axis_uart_tx_arbiter_pkg.sv
// uart_arb_pkg: shared types, counter width and width helper for the UART TX arbiter
package uart_arb_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA} arb_state_t;
  localparam int CNT_W = 16;
  function automatic int clog2_min1(input int n);
    return n <= 1 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/axis_uart_tx_arbiter_if.sv
// axis_uart_tx_arbiter_if: per-source AXI-Stream inputs and the single merged AXI-Stream output
interface axis_uart_tx_arbiter_if #(parameter int NUM_SRC = 4);
  logic [8*NUM_SRC-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]   s_axis_tvalid;
  logic [NUM_SRC-1:0]   s_axis_tlast;
  logic [NUM_SRC-1:0]   s_axis_tready;
  logic [7:0]           m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/axis_uart_tx_arbiter_rr_pick.sv
// rr_pick: first requester at or after ptr, ascending with wrap
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IW = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      gnt_idx,
  output logic               any_req
);
  always_comb begin
    gnt_idx = '0;
    any_req = |req;
    // Scan from the farthest offset down so the nearest requester wins last.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      j = j >= NUM_SRC ? j - NUM_SRC : j;
      if (req[j]) gnt_idx = IW'(j);
    end
  end
endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// axis_uart_tx_arbiter: packet-granular round-robin sharing of one UART TX stream
module axis_uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ADD_ID = 1,
  parameter int MAX_PKT_LEN = 256,
  localparam int IW = clog2_min1(NUM_SRC)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axis_uart_tx_arbiter_if.slave bus,
  output logic [IW-1:0]         grant_id,
  output logic                  busy,
  output logic                  pkt_trunc
);
  arb_state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, grant_n, pick;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic any_req, sel_valid, sel_last, hs, release_pkt;
  logic [7:0] sel_data;
  rr_pick #(.NUM_SRC(NUM_SRC), .IW(IW)) u_pick (
    .req(bus.s_axis_tvalid),
    .ptr(ptr),
    .gnt_idx(pick),
    .any_req(any_req)
  );
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      ptr <= '0;
      grant_id <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      grant_id <= grant_n;
      cnt <= cnt_n;
    end
  always_comb begin
    sel_data = bus.s_axis_tdata[{grant_id, 3'b000} +: 8];
    sel_valid = bus.s_axis_tvalid[grant_id];
    sel_last = bus.s_axis_tlast[grant_id];
    hs = state == DATA && sel_valid && bus.m_axis_tready;
    pkt_trunc = hs && !sel_last && cnt == CNT_W'(MAX_PKT_LEN - 1);
    release_pkt = hs && (sel_last || pkt_trunc);
    busy = state != IDLE;
    bus.m_axis_tvalid = state == HDR || (state == DATA && sel_valid);
    bus.m_axis_tdata = state == HDR ? 8'(grant_id) : state == DATA ? sel_data : 8'h00;
    bus.s_axis_tready = state == DATA && bus.m_axis_tready ? NUM_SRC'(1) << grant_id : '0;
    state_n = state;
    ptr_n = ptr;
    grant_n = grant_id;
    cnt_n = hs ? cnt + 1'b1 : cnt;
    if (state == IDLE && any_req) begin
      state_n = ADD_ID != 0 ? HDR : DATA;
      grant_n = pick;
    end
    if (state == HDR && bus.m_axis_tready) state_n = DATA;
    // Normal end and forced release share the same hand-off to the next source.
    if (release_pkt) begin
      state_n = IDLE;
      cnt_n = '0;
      ptr_n = grant_id == IW'(NUM_SRC - 1) ? '0 : grant_id + 1'b1;
    end
  end
endmodule
